// File: rtl/button_conditioner_pkg.sv
// ============================================================================
// Module   : button_conditioner_pkg
// Brief    : Shared stopwatch constants: channel indices, debounce FSM state
//            encodings and default timing parameters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_conditioner_pkg;

    localparam int BTN_START = 0;
    localparam int BTN_LAP   = 1;
    localparam int BTN_CLEAR = 2;
    localparam int NUM_BTN   = 3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 5000;
    localparam int DEFAULT_HOLD_CYCLES     = 1000000;

    localparam logic [1:0] ST_STABLE_LO = 2'd0;
    localparam logic [1:0] ST_PEND_HI   = 2'd1;
    localparam logic [1:0] ST_STABLE_HI = 2'd2;
    localparam logic [1:0] ST_PEND_LO   = 2'd3;

endpackage : button_conditioner_pkg

`default_nettype wire

// File: rtl/button_conditioner_if.sv
// ============================================================================
// Module   : button_conditioner_if
// Brief    : Raw button inputs and conditioned level/pulse outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_conditioner_if;
    import button_conditioner_pkg::*;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               clear_pulse;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  clear_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output clear_pulse
    );

endinterface : button_conditioner_if

`default_nettype wire

// File: rtl/button_conditioner_debounce_channel.sv
// ============================================================================
// Module   : debounce_channel
// Brief    : One button: 2-flop synchronizer, 4-state debounce FSM with a
//            saturating stability counter, and a rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  wire logic clk,
    input  wire logic res,
    input  wire logic i_btn_raw,
    output logic      o_btn_level,
    output logic      o_btn_pulse
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    logic          sync1_q, sync2_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] w_cnt_inc;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;

    assign w_cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_STABLE_LO: begin
                if (sync2_q) begin
                    state_d = ST_PEND_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PEND_HI: begin
                if (!sync2_q) begin
                    state_d = ST_STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX) begin
                    state_d = ST_STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d   = w_cnt_inc;
                end
            end
            ST_STABLE_HI: begin
                if (!sync2_q) begin
                    state_d = ST_PEND_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PEND_LO: begin
                if (sync2_q) begin
                    state_d = ST_STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX) begin
                    state_d = ST_STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d   = w_cnt_inc;
                end
            end
            default: begin
                state_d = ST_STABLE_LO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= i_btn_raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_btn_level = level_q;
    assign o_btn_pulse = pulse_q;

endmodule : debounce_channel

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module   : button_conditioner
// Brief    : Debounces the three stopwatch buttons and derives the clear
//            request. Define HOLD_CLEAR_EN to require a long press on clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
    input  wire logic            clk,
    input  wire logic            res,
    button_conditioner_if.slave  bus
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_pulse;

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
        $error("button_conditioner: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk         (clk),
            .res         (res),
            .i_btn_raw   (bus.btn_raw[i]),
            .o_btn_level (w_level[i]),
            .o_btn_pulse (w_pulse[i])
        );
    end

    assign bus.btn_level = w_level;
    assign bus.btn_pulse = w_pulse;

`ifdef HOLD_CLEAR_EN
    localparam int            HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          clear_pulse_q, clear_pulse_d;

    // Counter parks at HOLD_MAX, so a long press fires exactly once.
    always_comb begin
        hold_cnt_d    = '0;
        clear_pulse_d = 1'b0;
        if (w_level[BTN_CLEAR]) begin
            hold_cnt_d    = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HW'(1);
            clear_pulse_d = (hold_cnt_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            hold_cnt_q    <= '0;
            clear_pulse_q <= 1'b0;
        end else begin
            hold_cnt_q    <= hold_cnt_d;
            clear_pulse_q <= clear_pulse_d;
        end
    end

    assign bus.clear_pulse = clear_pulse_q;
`else
    assign bus.clear_pulse = w_pulse[BTN_CLEAR];
`endif

endmodule : button_conditioner

`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 5000: consecutive stable cycles required to accept a new input level (5 ms at 1 MHz).
REQ-002 Parameter HOLD_CYCLES, default 1000000: clear-button hold time in cycles (1 s at 1 MHz); used only with HOLD_CLEAR_EN.
REQ-003 clk  input  1  single system clock (1 MHz); all logic on rising edge.
REQ-004 res  input  1  reset; synchronous, active-high.
REQ-005 btn_raw  input  3  asynchronous push-button levels: [0] start_stop, [1] lap_time, [2] clear.
REQ-006 btn_level  output  3  debounced level per channel.
REQ-007 btn_pulse  output  3  one-cycle pulse per channel on an accepted rising edge of the debounced level.
REQ-008 clear_pulse  output  1  one-cycle stopwatch clear request; feeds the counter-chain reset logic.

Function
REQ-009 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Each channel SHALL run a 4-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-011 STABLE_LO -> PEND_HI when the synced input is 1; STABLE_HI -> PEND_LO when the synced input is 0; the stability counter loads 1 on entry.
REQ-012 In PEND_x: synced input returns to the old level -> back to STABLE_(old), counter cleared, no output change.
REQ-013 In PEND_x: counter reaches DEBOUNCE_CYCLES with input still at the new level -> STABLE_(new); btn_level updates on the same edge.
REQ-014 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter saturates and never wraps.
REQ-015 btn_pulse[i] SHALL be high for exactly one cycle, on the edge where btn_level[i] goes 0->1; it is never asserted on 1->0.
REQ-016 Latency: btn_raw held high from edge N SHALL give btn_level/btn_pulse high after edge N+2+DEBOUNCE_CYCLES.
REQ-017 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change.
REQ-018 Channels SHALL be independent; simultaneous pulses on several channels are legal and SHALL all be reported in the same cycle.
REQ-019 A held button SHALL produce exactly one pulse; there is no auto-repeat.

Reset
REQ-020 While res=1: synchronizers=0, FSMs=STABLE_LO, counters=0, btn_level=0, btn_pulse=0, clear_pulse=0, hold counter=0.
REQ-021 Reset asserted mid-debounce SHALL abort the pending transition; a button still held after res falls SHALL be re-debounced from zero and SHALL then produce one pulse.

Configuration
REQ-022 Macro HOLD_CLEAR_EN.
REQ-023 Defined: clear_pulse SHALL assert one cycle when btn_level[2] has been high for HOLD_CYCLES consecutive cycles. The hold counter clears when btn_level[2] falls and saturates, giving one pulse per hold. btn_pulse[2] is unaffected.
REQ-024 Not defined: clear_pulse SHALL equal btn_pulse[2]; no hold counter is instantiated.

Structure
REQ-025 The shared stopwatch package/include SHALL hold the channel index constants (BTN_START=0, BTN_LAP=1, BTN_CLEAR=2), the FSM state encodings and the DEBOUNCE_CYCLES/HOLD_CYCLES defaults.
REQ-026 One sub-module, debounce_channel (synchronizer, FSM, counter, pulse), SHALL be instantiated 3 times; the hold logic stays in the top module.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10)
REQ-027 Clean press: btn_raw[0] 0->1 at edge 10 and held -> btn_level[0]=1 and a single btn_pulse[0] after edge 16; no further pulses while held.
REQ-028 Bounce: btn_raw[1] high for 3 cycles, low for 2, then held high -> no output during the bounce; one pulse 6 edges after the final rise.
REQ-029 Release: btn_raw[0] falls after a stable press -> btn_level[0]=0 after 6 edges, no pulse; a 2-cycle low glitch while held -> no change.
REQ-030 Simultaneous: all 3 bits rise on the same edge -> all btn_pulse bits high in the same single cycle.
REQ-031 Reset mid-debounce: res=1 for 1 cycle, 2 edges after btn_raw[2] rises, button held -> outputs stay 0 during reset; pulse 6 edges after res falls.
REQ-032 HOLD_CLEAR_EN defined: clear held 20 cycles -> one clear_pulse, 10 cycles after btn_level[2] rises; undefined -> clear_pulse equals btn_pulse[2] every cycle.
